// File: rtl/four_bank_mem_responder_if.sv
// Request/response bundle between the cache controller and the four-bank memory responder.
// The controller drives the request side; the responder returns data, stall, busy and err.
interface four_bank_mem_responder_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  modport master (
    output addr, data_in, rd, wr,
    input  data_out, stall, busy, err
  );

  modport slave (
    input  addr, data_in, rd, wr,
    output data_out, stall, busy, err
  );
endinterface

// File: rtl/four_bank_mem_responder.sv
// Four-bank interleaved word memory with per-bank busy counters and a fixed 2-cycle read
// pipeline. Consecutive word addresses map to consecutive banks, so a line streams unstalled.
module four_bank_mem_responder #(
  parameter int unsigned ROW_BITS    = 8,
  parameter int unsigned BUSY_CYCLES = 4
) (
  input logic                      clk,
  input logic                      rst,
  four_bank_mem_responder_if.slave bus
);

  localparam int unsigned CntW  = $clog2(BUSY_CYCLES + 1);
  localparam int unsigned Words = 4 << ROW_BITS;

  logic [1:0]          bank;
  logic [ROW_BITS-1:0] row;
  logic [ROW_BITS+1:0] idx;
  logic                req_one;
  logic                aligned;
  logic                illegal;
  logic                accept;
  logic [3:0]          busy;

  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];

  logic [15:0] mem_q [Words];
  logic [15:0] rd_data1_q, rd_data2_q;
  logic        rd_valid1_q, rd_valid2_q;
  logic        err_q;

  // Address bits above the row field alias onto the same words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[15:ROW_BITS+3];

  assign bank    = bus.addr[2:1];
  assign row     = bus.addr[ROW_BITS+2:3];
  assign idx     = {bank, row};
  assign req_one = bus.rd ^ bus.wr;
  assign aligned = ~bus.addr[0];
  assign illegal = (bus.rd & bus.wr) | ((bus.rd | bus.wr) & bus.addr[0]);
  assign accept  = req_one & aligned & ~busy[bank];

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      busy[b]  = (cnt_q[b] != '0);
      cnt_d[b] = busy[b] ? cnt_q[b] - CntW'(1) : cnt_q[b];
      if (accept && (bank == 2'(b))) begin
        cnt_d[b] = CntW'(BUSY_CYCLES);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        cnt_q[b] <= '0;
      end
      rd_valid1_q <= 1'b0;
      rd_valid2_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
      rd_valid1_q <= accept & bus.rd;
      rd_valid2_q <= rd_valid1_q;
      err_q       <= illegal;
    end
  end

  // Array and data stages are not reset; the valid bits gate what reaches data_out.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      mem_q[idx] <= bus.data_in;
    end
    if (accept && bus.rd) begin
      rd_data1_q <= mem_q[idx];
    end
    rd_data2_q <= rd_data1_q;
  end

  assign bus.data_out = rd_valid2_q ? rd_data2_q : 16'h0000;
  assign bus.stall    = req_one & aligned & busy[bank];
  assign bus.busy     = busy;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_four_bank_mem_responder.sv
// Directed bench for four_bank_mem_responder: single writes/reads, line fill, same-bank stall,
// illegal requests, reset during an in-flight read and row wrap-around.
module tb_four_bank_mem_responder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  four_bank_mem_responder_if bus ();

  four_bank_mem_responder #(
    .ROW_BITS    (8),
    .BUSY_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d);
    bus.rd      = r;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
  endtask

  task automatic idle(input int n);
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    set_req(1'b0, 1'b1, a, d);
    #1;
    check_eq("wr_stall", {15'h0, bus.stall}, 16'h0000);
    tick();
    idle(5);
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
    set_req(1'b1, 1'b0, a, 16'h0000);
    #1;
    check_eq("rd_stall", {15'h0, bus.stall}, 16'h0000);
    tick();
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    #1;
    check_eq(tag, bus.data_out, exp);
    idle(4);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    #12;
    check_eq("rst_data_out", bus.data_out, 16'h0000);
    check_eq("rst_err", {15'h0, bus.err}, 16'h0000);
    check_eq("rst_busy", {12'h0, bus.busy}, 16'h0000);
    check_eq("rst_stall", {15'h0, bus.stall}, 16'h0000);
    tick();
    rst = 1'b0;
    tick();

    // 1: single write then read, data only in T+2
    do_write(16'h0010, 16'hBEEF);
    set_req(1'b1, 1'b0, 16'h0010, 16'h0000);
    #1;
    check_eq("t1_stall", {15'h0, bus.stall}, 16'h0000);
    check_eq("t1_dout_T", bus.data_out, 16'h0000);
    tick();
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    check_eq("t1_dout_T1", bus.data_out, 16'h0000);
    tick();
    check_eq("t1_dout_T2", bus.data_out, 16'hBEEF);
    tick();
    check_eq("t1_dout_T3", bus.data_out, 16'h0000);
    check_eq("t1_err", {15'h0, bus.err}, 16'h0000);
    idle(4);

    // 2: line fill across all four banks
    do_write(16'h0020, 16'h1111);
    do_write(16'h0022, 16'h2222);
    do_write(16'h0024, 16'h3333);
    do_write(16'h0026, 16'h4444);
    set_req(1'b1, 1'b0, 16'h0020, 16'h0000);
    #1;
    check_eq("t2_busy_T0", {12'h0, bus.busy}, 16'h0000);
    check_eq("t2_stall_T0", {15'h0, bus.stall}, 16'h0000);
    tick();
    set_req(1'b1, 1'b0, 16'h0022, 16'h0000);
    #1;
    check_eq("t2_busy_T1", {12'h0, bus.busy}, 16'h0001);
    check_eq("t2_stall_T1", {15'h0, bus.stall}, 16'h0000);
    tick();
    set_req(1'b1, 1'b0, 16'h0024, 16'h0000);
    #1;
    check_eq("t2_busy_T2", {12'h0, bus.busy}, 16'h0003);
    check_eq("t2_stall_T2", {15'h0, bus.stall}, 16'h0000);
    check_eq("t2_dout_T2", bus.data_out, 16'h1111);
    tick();
    set_req(1'b1, 1'b0, 16'h0026, 16'h0000);
    #1;
    check_eq("t2_busy_T3", {12'h0, bus.busy}, 16'h0007);
    check_eq("t2_stall_T3", {15'h0, bus.stall}, 16'h0000);
    check_eq("t2_dout_T3", bus.data_out, 16'h2222);
    tick();
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    check_eq("t2_busy_T4", {12'h0, bus.busy}, 16'h000F);
    check_eq("t2_dout_T4", bus.data_out, 16'h3333);
    tick();
    check_eq("t2_busy_T5", {12'h0, bus.busy}, 16'h000E);
    check_eq("t2_dout_T5", bus.data_out, 16'h4444);
    tick();
    check_eq("t2_dout_T6", bus.data_out, 16'h0000);
    idle(5);

    // 3: same-bank back-to-back stalls until counter expires
    do_write(16'h0008, 16'h5678);
    set_req(1'b0, 1'b1, 16'h0000, 16'hCAFE);
    #1;
    check_eq("t3_wr_stall", {15'h0, bus.stall}, 16'h0000);
    tick();
    set_req(1'b1, 1'b0, 16'h0008, 16'h0000);
    for (int i = 1; i <= 4; i++) begin
      #1;
      check_eq($sformatf("t3_stall_T%0d", i), {15'h0, bus.stall}, 16'h0001);
      tick();
    end
    #1;
    check_eq("t3_stall_T5", {15'h0, bus.stall}, 16'h0000);
    tick();
    // Stalled write that is then abandoned must leave memory untouched.
    set_req(1'b0, 1'b1, 16'h0008, 16'hDEAD);
    #1;
    check_eq("t3_stall_T6", {15'h0, bus.stall}, 16'h0001);
    tick();
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    check_eq("t3_dout_T7", bus.data_out, 16'h5678);
    tick();
    check_eq("t3_dout_T8", bus.data_out, 16'h0000);
    idle(5);
    do_read("t3_readback_0008", 16'h0008, 16'h5678);

    // 4: illegal requests
    do_write(16'h0004, 16'h7777);
    set_req(1'b1, 1'b1, 16'h0004, 16'h9999);
    #1;
    check_eq("t4_stall_A", {15'h0, bus.stall}, 16'h0000);
    tick();
    set_req(1'b1, 1'b0, 16'h0005, 16'h0000);
    #1;
    check_eq("t4_err_A1", {15'h0, bus.err}, 16'h0001);
    check_eq("t4_busy_A1", {12'h0, bus.busy}, 16'h0000);
    check_eq("t4_stall_A1", {15'h0, bus.stall}, 16'h0000);
    tick();
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    check_eq("t4_err_A2", {15'h0, bus.err}, 16'h0001);
    check_eq("t4_busy_A2", {12'h0, bus.busy}, 16'h0000);
    tick();
    check_eq("t4_err_A3", {15'h0, bus.err}, 16'h0000);
    check_eq("t4_dout_A3", bus.data_out, 16'h0000);
    idle(2);
    do_read("t4_readback_0004", 16'h0004, 16'h7777);

    // 5: reset while a read is in flight
    set_req(1'b1, 1'b0, 16'h0010, 16'h0000);
    #1;
    tick();
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b1;
    #1;
    check_eq("t5_dout_rst", bus.data_out, 16'h0000);
    check_eq("t5_busy_rst", {12'h0, bus.busy}, 16'h0000);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("t5_dout_post%0d", i), bus.data_out, 16'h0000);
      tick();
    end
    do_read("t5_readback_0010", 16'h0010, 16'hBEEF);
    do_read("t5_readback_0020", 16'h0020, 16'h1111);
    do_read("t5_readback_0000", 16'h0000, 16'hCAFE);

    // 6: high address bits wrap onto row 0
    do_write(16'h0800, 16'h1234);
    do_read("t6_wrap_0000", 16'h0000, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/four_bank_mem_responder.md
Name: four_bank_mem_responder

Overview:
- Memory-side responder for the cache controller's multi-cycle fill and writeback traffic.
- Four interleaved banks; each accepts one word request, then stays busy for 4 cycles.
- Returns read data a fixed 2 cycles after acceptance.
- The controller's ACCESS_READ_0..3 and ACCESS_WRITE/WAIT_FOR_READ_0..3 sequences issue one word per cycle to consecutive banks, so a 4-word line streams with no stall.

Parameters:
ROW_BITS, 8, log2 of words per bank; memory is 4*2^ROW_BITS 16-bit words.
BUSY_CYCLES, 4, cycles a bank stays busy after accepting a request.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
addr  input  16  byte address; bank = addr[2:1], row = addr[ROW_BITS+2:3], higher bits ignored (wrap).
data_in  input  16  write data.
rd  input  1  read request, sampled every cycle.
wr  input  1  write request, sampled every cycle.
data_out  output  16  read data, valid exactly 2 cycles after read acceptance, else 16'h0000.
stall  output  1  combinational; 1 when a request targets a busy bank. Request not accepted.
busy  output  4  per-bank busy flags (busy[b] = counter b nonzero).
err  output  1  registered; pulses 1 cycle after an illegal request.

Behaviour:
- Reset, asynchronous and active-high:
  - busy counters 0; read pipeline valid bits 0.
  - data_out 0, err 0.
  - Memory array contents not reset.
  - In-flight reads are dropped; no data_out pulse after reset releases.
- Illegal request in cycle T: (rd & wr), or (rd|wr) & addr[0].
  - Not accepted: no memory write, no busy change, no read issued.
  - err=1 during T+1 only; stall=0 for it.
- stall = (rd ^ wr) & ~addr[0] & busy[addr[2:1]], combinational from current inputs and counters.
- Accept in cycle T when (rd ^ wr) & ~addr[0] & ~busy[bank].
  - Counter[bank] loads BUSY_CYCLES at the T edge and decrements by 1 each cycle while nonzero.
  - busy[bank]=1 in T+1..T+BUSY_CYCLES; next accept to that bank earliest at T+BUSY_CYCLES+1.
- Banks are independent. One request per cycle max (single port), so different banks can be accepted in consecutive cycles.
- Write accepted at T: mem[bank][row] <= data_in at the T edge.
- Read accepted at T:
  - Samples mem[bank][row] as of the T edge; a write accepted at T-1 to the same word is visible.
  - Data travels a 2-stage registered pipeline with a valid bit.
  - data_out = word during T+2; 0 when stage-2 valid is 0.
- Reads accepted in consecutive cycles (different banks) produce data_out in consecutive cycles, in order.
- Stalled requests have no side effects. The requester holds rd/wr/addr/data_in until stall=0; the responder keeps no memory of them.
- Idle (rd=wr=0): stall=0, counters keep decrementing, pipeline drains.

Test Plan:
1. Reset, write 16'hBEEF to addr 16'h0010 (bank 0), idle 5, read 16'h0010 at cycle T -> data_out=16'hBEEF at T+2 only, 0 at T+1 and T+3; err stays 0.
2. Line fill: reads to 16'h0020, 0022, 0024, 0026 on 4 consecutive cycles -> stall=0 throughout; busy goes 0001,0011,0111,1111; data_out returns the 4 prewritten words on cycles T+2..T+5 in order.
3. Same-bank back-to-back: write 16'h0000 at T, then read 16'h0008 (bank 0) from T+1 -> stall=1 on T+1..T+4, accepted at T+5, data returned at T+7; no write occurs during stalled cycles.
4. Illegal requests: rd=wr=1 at addr 16'h0004, then rd=1 at addr 16'h0005 -> err=1 on each following cycle; busy stays 0; memory unchanged (readback equals prior contents).
5. Reset mid-read: read accepted at T, rst asserted during T+1 -> data_out=0, busy=0 immediately; no data_out pulse after release; previously written words still read back correctly.
6. Wrap: with ROW_BITS=8, write 16'h1234 to addr 16'h0800, read addr 16'h0000 -> data_out=16'h1234.
